// File: rtl/dmem_access.sv
// MEM-stage data-SRAM access unit: one req/addr_ok/data_ok transaction per load/store, with pipeline stall.
// Optional misalignment trapping is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [7:0]  alucontrolM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        flushM,
    input  logic        stall_other,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] readdatatmpM,
    output logic        adelM,
    output logic        adesM,
    output logic        dmem_stallM
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_discard;
    logic        w_discard_nxt;
    logic [31:0] r_rdata;

    logic [1:0]  w_size;
    logic        w_half_op;
    logic        w_word_op;
    logic        w_adel;
    logic        w_ades;
    logic        w_start;
    logic        w_busy;
    logic        w_discard_now;
    logic        w_dok;
    logic        w_capture;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    // Op decode: access size and whether the op carries an alignment requirement
    always_comb begin
        w_size    = 2'd2;
        w_half_op = 1'b0;
        w_word_op = 1'b0;
        case (alucontrolM)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                w_size = 2'd0;
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                w_size    = 2'd1;
                w_half_op = 1'b1;
            end
            EXE_LW_OP, EXE_SW_OP: begin
                w_size    = 2'd2;
                w_word_op = 1'b1;
            end
            default: begin
                w_size = 2'd2;
            end
        endcase
    end

`ifdef DMEM_ADDR_CHECK_EN
    // Misalignment detection: halfword needs addr[0]==0, word needs addr[1:0]==0
    always_comb begin
        w_adel = 1'b0;
        w_ades = 1'b0;
        if (memenM && ((w_half_op && aluoutM[0]) || (w_word_op && (aluoutM[1:0] != 2'b00)))) begin
            w_adel = ~memwriteM;
            w_ades = memwriteM;
        end else begin
            w_adel = 1'b0;
            w_ades = 1'b0;
        end
    end
`else
    assign w_adel = 1'b0 & w_half_op & w_word_op;
    assign w_ades = 1'b0;
`endif

    // Store lane formatting: strobes from size/offset, data replicated across lanes
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = writedataM;
        case (w_size)
            2'd0: begin
                w_wstrb = 4'b0001 << aluoutM[1:0];
                w_wdata = {4{writedataM[7:0]}};
            end
            2'd1: begin
                w_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{writedataM[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = writedataM;
            end
        endcase
        if (!memwriteM) begin
            w_wstrb = 4'b0000;
        end else begin
            w_wstrb = w_wstrb;
        end
    end

    assign w_busy        = (r_state == ST_ADDR) || (r_state == ST_DATA);
    // A flush while a transaction is in flight takes effect in the same cycle
    assign w_discard_now = r_discard | (flushM & w_busy);
    assign w_dok         = (r_state == ST_DATA) & data_sram_data_ok;
    assign w_capture     = w_dok & ~w_discard_now;
    assign w_start       = memenM & ~flushM & ~w_adel & ~w_ades & (r_state == ST_IDLE) & ~r_discard;

    // Next-state and discard-flag logic
    always_comb begin
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = data_sram_addr_ok ? ST_DATA : ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (data_sram_addr_ok) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (data_sram_data_ok) begin
                    if (w_discard_now || !stall_other) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DONE: begin
                if (!stall_other) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_dok) begin
            w_discard_nxt = 1'b0;
        end else if (w_busy && flushM) begin
            w_discard_nxt = 1'b1;
        end else begin
            w_discard_nxt = r_discard;
        end
    end

    // State, discard flag and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_discard <= 1'b0;
            r_rdata   <= 32'h0000_0000;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
            if (w_capture) begin
                r_rdata <= data_sram_rdata;
            end
        end
    end

    // Bus request and stall outputs, forced low while in reset
    always_comb begin
        data_sram_req = 1'b0;
        dmem_stallM   = 1'b0;
        if (rst) begin
            data_sram_req = 1'b0;
            dmem_stallM   = 1'b0;
        end else begin
            data_sram_req = ((r_state == ST_IDLE) & w_start) | (r_state == ST_ADDR);
            if (w_discard_now) begin
                dmem_stallM = memenM & ~flushM;
            end else begin
                dmem_stallM = ((r_state == ST_IDLE) & w_start) | (r_state == ST_ADDR)
                            | ((r_state == ST_DATA) & ~data_sram_data_ok);
            end
        end
    end

    assign adelM           = w_adel & ~rst;
    assign adesM           = w_ades & ~rst;
    assign data_sram_wr    = memwriteM;
    assign data_sram_size  = w_size;
    assign data_sram_addr  = aluoutM;
    assign data_sram_wstrb = w_wstrb;
    assign data_sram_wdata = w_wdata;
    assign readdatatmpM    = w_capture ? data_sram_rdata : r_rdata;

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: vector table, directed multi-cycle sequences, randomized accesses vs a reference model.
module tb_dmem_access;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, flushM, stall_other;
    logic [7:0]  alucontrolM;
    logic [31:0] aluoutM, writedataM;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata, readdatatmpM;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic        adelM, adesM, dmem_stallM;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rd;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        wr;
    } vec_t;
    vec_t vecs[11];

    logic [7:0] ops[8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    int         szs[8] = '{0, 0, 1, 1, 2, 0, 1, 2};
    bit         sts[8] = '{0, 0, 0, 0, 0, 1, 1, 1};

    dmem_access dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM),
        .alucontrolM(alucontrolM), .aluoutM(aluoutM), .writedataM(writedataM),
        .flushM(flushM), .stall_other(stall_other),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .readdatatmpM(readdatatmpM),
        .adelM(adelM), .adesM(adesM), .dmem_stallM(dmem_stallM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: strobe mask covers 2^size bytes at the size-aligned offset
    function automatic logic [3:0] m_strb(input int sz, input logic [31:0] a, input bit st);
        int n, off;
        if (!st) return 4'b0000;
        n   = 1 << sz;
        off = int'(a[1:0]) & (4 - n);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
        if (sz == 0) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (sz == 1) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    // One access; addr_ok after aok cycles, data_ok dokx cycles after the earliest slot, stall_other for so_len cycles
    task automatic run_access(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                              input int aok, input int dokx, input int so_len, input logic [31:0] rd,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata,
                              input logic [1:0] e_size, input logic e_wr);
        int dokc, total;
        dokc  = aok + 1 + dokx;
        total = dokc + so_len + 1;
        memenM = 1'b1; memwriteM = e_wr; alucontrolM = op; aluoutM = a; writedataM = wd; flushM = 1'b0;
        for (int c = 0; c < total; c++) begin
            data_sram_addr_ok = (c == aok);
            data_sram_data_ok = (c == dokc);
            data_sram_rdata   = (c == dokc) ? rd : $urandom;
            stall_other       = (c >= dokc) && (c < dokc + so_len);
            #1;
            chk("req", 32'(data_sram_req), 32'(c <= aok));
            chk("stall", 32'(dmem_stallM), 32'(c < dokc));
            if (c == 0) begin
                chk("size", 32'(data_sram_size), 32'(e_size));
                chk("wstrb", 32'(data_sram_wstrb), 32'(e_strb));
                chk("wr", 32'(data_sram_wr), 32'(e_wr));
                chk("addr", data_sram_addr, a);
                chk("adel", 32'(adelM), 32'd0);
                chk("ades", 32'(adesM), 32'd0);
                if (e_wr) chk("wdata", data_sram_wdata, e_wdata);
            end
            if (c >= dokc) chk("rdtmp", readdatatmpM, rd);
            step();
        end
        memenM = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; stall_other = 1'b0;
        #1;
        chk("idle_req", 32'(data_sram_req), 32'd0);
        chk("idle_stall", 32'(dmem_stallM), 32'd0);
        chk("rdtmp_hold", readdatatmpM, rd);
        last_rd = rd;
        step();
    endtask

    initial begin
        vecs[0]  = '{OP_SB,  32'h203, 32'h1234_5678, 4'b1000, 32'h7878_7878, 2'd0, 1'b1};
        vecs[1]  = '{OP_SB,  32'h200, 32'h1234_5678, 4'b0001, 32'h7878_7878, 2'd0, 1'b1};
        vecs[2]  = '{OP_SB,  32'h201, 32'h1234_5678, 4'b0010, 32'h7878_7878, 2'd0, 1'b1};
        vecs[3]  = '{OP_SH,  32'h202, 32'h1234_5678, 4'b1100, 32'h5678_5678, 2'd1, 1'b1};
        vecs[4]  = '{OP_SH,  32'h200, 32'h1234_5678, 4'b0011, 32'h5678_5678, 2'd1, 1'b1};
        vecs[5]  = '{OP_SW,  32'h204, 32'h1234_5678, 4'b1111, 32'h1234_5678, 2'd2, 1'b1};
        vecs[6]  = '{OP_LB,  32'h201, 32'h1234_5678, 4'b0000, 32'h0,         2'd0, 1'b0};
        vecs[7]  = '{OP_LHU, 32'h202, 32'h1234_5678, 4'b0000, 32'h0,         2'd1, 1'b0};
        vecs[8]  = '{OP_LW,  32'h100, 32'h1234_5678, 4'b0000, 32'h0,         2'd2, 1'b0};
        vecs[9]  = '{OP_SB,  32'h102, 32'hCAFE_BABE, 4'b0100, 32'hBEBE_BEBE, 2'd0, 1'b1};
        vecs[10] = '{OP_SH,  32'h306, 32'hCAFE_BABE, 4'b1100, 32'hBABE_BABE, 2'd1, 1'b1};

        rst = 1'b1; memenM = 1'b1; memwriteM = 1'b0; alucontrolM = OP_LW; aluoutM = 32'h100;
        writedataM = 32'h0; flushM = 1'b0; stall_other = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        @(negedge clk);
        #1;
        chk("rst_req", 32'(data_sram_req), 32'd0);
        chk("rst_stall", 32'(dmem_stallM), 32'd0);
        step();
        rst = 1'b0; memenM = 1'b0;
        #1;
        chk("rst_rdtmp", readdatatmpM, 32'h0);
        chk("rst_idle_req", 32'(data_sram_req), 32'd0);
        last_rd = 32'h0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].op, vecs[i].addr, vecs[i].wd, 0, 0, 0, $urandom,
                       vecs[i].strb, vecs[i].wdata, vecs[i].size, vecs[i].wr);
        end

        // Zero-wait LW, wait states, stall_other hold
        run_access(OP_LW, 32'h100, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 4'b0000, 32'h0, 2'd2, 1'b0);
        run_access(OP_LW, 32'h104, 32'h0, 2, 2, 0, 32'h1357_9BDF, 4'b0000, 32'h0, 2'd2, 1'b0);
        run_access(OP_LW, 32'h108, 32'h0, 0, 0, 3, 32'hA5A5_A5A5, 4'b0000, 32'h0, 2'd2, 1'b0);

        // Flush while waiting for data: stall drops, next load waits for the old data_ok
        memenM = 1'b1; memwriteM = 1'b0; alucontrolM = OP_LW; aluoutM = 32'h100;
        data_sram_addr_ok = 1'b1;
        #1;
        chk("fl_c0_req", 32'(data_sram_req), 32'd1);
        chk("fl_c0_stall", 32'(dmem_stallM), 32'd1);
        step();
        data_sram_addr_ok = 1'b0; flushM = 1'b1;
        #1;
        chk("fl_c1_stall", 32'(dmem_stallM), 32'd0);
        chk("fl_c1_req", 32'(data_sram_req), 32'd0);
        step();
        flushM = 1'b0; aluoutM = 32'h200;
        #1;
        chk("fl_c2_req", 32'(data_sram_req), 32'd0);
        chk("fl_c2_stall", 32'(dmem_stallM), 32'd1);
        step();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        #1;
        chk("fl_c3_req", 32'(data_sram_req), 32'd0);
        chk("fl_c3_stall", 32'(dmem_stallM), 32'd1);
        chk("fl_c3_rdtmp", readdatatmpM, last_rd);
        step();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0BAD_0BAD; data_sram_addr_ok = 1'b1;
        #1;
        chk("fl_c4_req", 32'(data_sram_req), 32'd1);
        chk("fl_c4_stall", 32'(dmem_stallM), 32'd1);
        chk("fl_c4_rdtmp", readdatatmpM, last_rd);
        step();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
        #1;
        chk("fl_c5_stall", 32'(dmem_stallM), 32'd0);
        chk("fl_c5_rdtmp", readdatatmpM, 32'h2222_2222);
        step();
        memenM = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        chk("fl_c6_req", 32'(data_sram_req), 32'd0);
        chk("fl_c6_rdtmp", readdatatmpM, 32'h2222_2222);
        last_rd = 32'h2222_2222;
        step();

        // Misaligned word load
`ifdef DMEM_ADDR_CHECK_EN
        memenM = 1'b1; memwriteM = 1'b0; alucontrolM = OP_LW; aluoutM = 32'h102;
        #1;
        chk("mis_adel", 32'(adelM), 32'd1);
        chk("mis_req", 32'(data_sram_req), 32'd0);
        chk("mis_stall", 32'(dmem_stallM), 32'd0);
        memwriteM = 1'b1; alucontrolM = OP_SW; aluoutM = 32'h201;
        #1;
        chk("mis_ades", 32'(adesM), 32'd1);
        chk("mis_s_req", 32'(data_sram_req), 32'd0);
        step();
        memenM = 1'b0;
        #1;
        chk("mis_after_req", 32'(data_sram_req), 32'd0);
        step();
`else
        run_access(OP_LW, 32'h102, 32'h0, 0, 0, 0, 32'h0F0F_0F0F, 4'b0000, 32'h0, 2'd2, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            int k, sz, aok, dokx, so;
            bit st;
            logic [31:0] a, wd, rd;
            k    = int'($urandom_range(0, 7));
            sz   = szs[k];
            st   = sts[k];
            a    = $urandom & 32'h0000_FFFC;
            if (sz == 0) a = a | 32'($urandom_range(0, 3));
            if (sz == 1) a = a | 32'(2 * $urandom_range(0, 1));
            wd   = $urandom;
            rd   = $urandom;
            aok  = int'($urandom_range(0, 3));
            dokx = int'($urandom_range(0, 3));
            so   = int'($urandom_range(0, 2));
            run_access(ops[k], a, wd, aok, dokx, so, rd,
                       m_strb(sz, a, st), m_wdata(sz, wd), 2'(sz), st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access.md
# dmem_access

Memory-stage data-SRAM access unit for the MIPS pipeline. It turns the MEM-stage load or store into one transaction on an SRAM-like request/handshake bus (`req`/`addr_ok`/`data_ok`). It computes size, byte strobes and lane-replicated write data, and detects misaligned addresses. It stalls the pipeline until the transaction completes, then presents the raw 32-bit read word (`readdatatmpM`) to the downstream load-data formatter, which does byte/half extraction and sign extension.

## Interface
Parameters:
- None; data and address paths are fixed at 32 bits.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `memenM` in 1 — MEM-stage instruction is a valid load/store.
- `memwriteM` in 1 — 1 = store, 0 = load.
- `alucontrolM` in 8 — op code: `EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP`.
- `aluoutM` in 32 — effective byte address.
- `writedataM` in 32 — store data (rt), unshifted.
- `flushM` in 1 — exception flush of the MEM stage.
- `stall_other` in 1 — the pipeline is held by another source.
- `data_sram_req` out 1 — transaction request.
- `data_sram_wr` out 1 — 1 = write.
- `data_sram_size` out 2 — 0 = byte, 1 = half, 2 = word.
- `data_sram_addr` out 32 — equal to `aluoutM`.
- `data_sram_wstrb` out 4 — byte write strobes.
- `data_sram_wdata` out 32 — lane-replicated write data.
- `data_sram_addr_ok` in 1 — request accepted.
- `data_sram_data_ok` in 1 — read data valid or write complete.
- `data_sram_rdata` in 32 — read data.
- `readdatatmpM` out 32 — raw read word for the formatter.
- `adelM` out 1 — load address error.
- `adesM` out 1 — store address error.
- `dmem_stallM` out 1 — stall request to hazard unit.

## Operation
- **start** = `memenM & ~flushM & ~adelM & ~adesM & (state==IDLE) & ~discard`.
- **FSM states:** IDLE, ADDR (request outstanding), DATA (awaiting `data_ok`), DONE (result held).
  - IDLE: if start and `addr_ok`, go to DATA; if start without `addr_ok`, go to ADDR.
  - ADDR: on `addr_ok`, go to DATA.
  - DATA: on `data_ok`, go to DONE if `stall_other`, otherwise go to IDLE.
  - DONE: go to IDLE when `~stall_other`.
- **Request:** `data_sram_req` = start in IDLE, or state==ADDR. Once asserted, `req` is never withdrawn before `addr_ok`.
- **Read-data capture:**
  - On `data_ok` in DATA, a register captures `data_sram_rdata`.
  - `readdatatmpM` = `data_sram_rdata` in that same cycle, otherwise the register. It holds through DONE.
- **Stall:** `dmem_stallM` = start in IDLE, or ADDR, or (DATA & `~data_ok`); it is 0 in DONE. While `discard`=1, `dmem_stallM` = `memenM & ~flushM`.
- **Flush in ADDR/DATA:**
  - `discard` is set and the stall drops immediately.
  - The bus transaction still completes and its data is not captured.
  - `discard` clears on `data_ok`; the FSM then returns to IDLE, even if `stall_other` is set.
  - No new request is issued until `discard` clears.
- **Store formatting:**
  - SB: `wstrb`=4'b0001<<`addr[1:0]`, `wdata`={4{`wd[7:0]`}}, size 0.
  - SH: `wstrb`=`addr[1]`?4'b1100:4'b0011, `wdata`={2{`wd[15:0]`}}, size 1.
  - SW: `wstrb`=4'b1111, `wdata`=`wd`, size 2.
- **Loads:** `wstrb`=0, `wr`=0; size is 0 for LB/LBU, 1 for LH/LHU, 2 for LW.
- **Reset:** state=IDLE, `discard`=0, read register=0.
  - While `rst`=1, `req`, `dmem_stallM`, `adelM` and `adesM` are forced to 0.
  - Reset mid-transaction abandons it; the memory side is reset by the same `rst`.

## Timing
- `addr_ok`, `data_ok` and `stall_other` are sampled on the rising edge.
- `data_ok` is honoured only in DATA, at earliest one cycle after `addr_ok`.
- `req`, `dmem_stallM`, `adelM`, `adesM` and the bus data outputs are combinational from MEM-stage inputs and state.
- **Zero-wait access:** cycle 0 has `req`, `addr_ok` and stall=1; cycle 1 has `data_ok` and stall=0. The pipeline advances at the end of cycle 1, so the penalty is 1 cycle.
- Each cycle of `addr_ok` delay adds one stall cycle; each extra cycle of `data_ok` delay adds one stall cycle.
- Inputs from the MEM stage are stable while `dmem_stallM` or `stall_other` is high.

## Configuration
- **`DMEM_ADDR_CHECK_EN` defined:**
  - `adelM`=1 for LH/LHU with `addr[0]`≠0, or LW with `addr[1:0]`≠0.
  - `adesM`=1 for SH with `addr[0]`≠0, or SW with `addr[1:0]`≠0.
  - A flagged access issues no request and asserts no stall.
- **Undefined:** `adelM`=`adesM`=0 and misaligned accesses are issued as-is, with size and strobes per the formatting rules.

## Test plan
- **LW zero-wait:** LW at 0x100; `addr_ok` in cycle 0, `data_ok`+`rdata`=0xDEADBEEF in cycle 1 → `req`=1 for 1 cycle, stall high only in cycle 0, `readdatatmpM`=0xDEADBEEF.
- **SB/SH strobes:**
  - SB, `wd`=0x12345678, addr 0x203 → `wstrb`=1000, `wdata`=0x78787878, size 0.
  - SH, addr 0x202 → `wstrb`=1100, `wdata`=0x56785678.
- **Wait states:** `addr_ok` after 2 cycles, `data_ok` after 3 more → `req` held steady for 3 cycles, stall for 5 cycles, one transaction only.
- **`stall_other` hold:** `data_ok`=0xA5A5A5A5 with `stall_other`=1 for 3 cycles → DONE, no new `req`, `readdatatmpM` stays 0xA5A5A5A5.
- **Flush in DATA:** stall drops the same cycle; the next load waits, with no `req`, until the old `data_ok`, then issues.
- **Misaligned LW 0x102 (macro on):** `adelM`=1, `req`=0, stall=0. With the macro off → `req`=1, size 2.
